// File: rtl/demux_route_if.sv
// Handshake bundle for demux_route: a single producer side and NUM_OUT consumer channels.
//   in_valid/in_ready/in_sel/in_data : producer transfer, routed by in_sel
//   out_valid/out_ready/out_data      : per-channel slot handshake, channel k at
//                                       out_data[k*DATA_W +: DATA_W]
//   err_sel                           : one-cycle pulse after an illegal select is dropped
// Modports: slave = the demux itself, master = producer plus consumers.
interface demux_route_if #(
  parameter int unsigned NUM_OUT = 31,
  parameter int unsigned DATA_W  = 2,
  parameter int unsigned SEL_W   = 5
);
  logic                      in_valid;
  logic                      in_ready;
  logic [SEL_W-1:0]          in_sel;
  logic [DATA_W-1:0]         in_data;
  logic [NUM_OUT-1:0]        out_valid;
  logic [NUM_OUT-1:0]        out_ready;
  logic [NUM_OUT*DATA_W-1:0] out_data;
  logic                      err_sel;

  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data, err_sel
  );

  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data, err_sel
  );
endinterface

// File: rtl/demux_route.sv
// 1-to-NUM_OUT demultiplexer with a one-entry holding slot per output channel.
// Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   bus_io      : demux_route_if.slave (producer handshake, per-channel outputs, err_sel)
//   drop_clr    : (DEMUX_STATS_EN only) synchronous clear of drop_cnt
//   drop_cnt    : (DEMUX_STATS_EN only) saturating count of illegal-select drops
// Optional feature: define DEMUX_STATS_EN to add the drop counter.
// A stalled channel only back-pressures transfers addressed to it; illegal selects
// are always accepted, dropped and flagged on err_sel one cycle later.
module demux_route #(
  parameter int unsigned NUM_OUT = 31,
  parameter int unsigned DATA_W  = 2,
  parameter int unsigned SEL_W   = 5
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef DEMUX_STATS_EN
  input  logic                drop_clr,
  output logic [7:0]          drop_cnt,
`endif
  demux_route_if.slave        bus_io
);

  logic [NUM_OUT-1:0]        valid_q, valid_d;
  logic [NUM_OUT*DATA_W-1:0] data_q, data_d;
  logic                      err_q, err_d;
  logic [NUM_OUT-1:0]        hit;
  logic                      sel_legal;
  logic                      ready;
  logic                      accept;

  // Decode the select; ready depends only on in_sel and the addressed slot, never in_valid.
  always_comb begin
    sel_legal = (32'(bus_io.in_sel) < NUM_OUT);
    hit       = '0;
    ready     = !sel_legal;
    for (int unsigned k = 0; k < NUM_OUT; k++) begin
      hit[k] = (32'(bus_io.in_sel) == k);
      if (hit[k]) begin
        ready = !valid_q[k] || bus_io.out_ready[k];
      end
    end
  end

  assign accept = bus_io.in_valid && ready;

  // Accept wins over drain, so a same-cycle accept and drain keeps the slot full
  // with the new word. Data is never cleared on drain.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int unsigned k = 0; k < NUM_OUT; k++) begin
      if (accept && hit[k]) begin
        valid_d[k]                   = 1'b1;
        data_d[k*DATA_W +: DATA_W]   = bus_io.in_data;
      end else if (valid_q[k] && bus_io.out_ready[k]) begin
        valid_d[k] = 1'b0;
      end
    end
    err_d = accept && !sel_legal;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign bus_io.in_ready  = ready;
  assign bus_io.out_valid = valid_q;
  assign bus_io.out_data  = data_q;
  assign bus_io.err_sel   = err_q;

`ifdef DEMUX_STATS_EN
  logic [7:0] cnt_q, cnt_d;

  // Counter moves on the same edge that raises err_sel; clear beats increment.
  always_comb begin
    cnt_d = cnt_q;
    if (drop_clr) begin
      cnt_d = 8'd0;
    end else if (err_d && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign drop_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_demux_route.sv
module tb_demux_route;
  localparam int NUM_OUT = 31;
  localparam int DATA_W  = 2;
  localparam int SEL_W   = 5;

  logic clk;
  logic rst_n;
`ifdef DEMUX_STATS_EN
  logic       drop_clr;
  logic [7:0] drop_cnt;
`endif

  demux_route_if #(.NUM_OUT(NUM_OUT), .DATA_W(DATA_W), .SEL_W(SEL_W)) bus ();

  demux_route #(.NUM_OUT(NUM_OUT), .DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef DEMUX_STATS_EN
    .drop_clr (drop_clr),
    .drop_cnt (drop_cnt),
`endif
    .bus_io   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: which channels hold a word, what word each last received,
  // whether an illegal word was dropped last cycle, and the drop count.
  bit         m_full [NUM_OUT];
  logic [1:0] m_data [NUM_OUT];
  bit         m_err;
  int         m_cnt;
  int         seen   [NUM_OUT];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NUM_OUT; k++) begin
      m_full[k] = 1'b0;
      m_data[k] = 2'b00;
    end
    m_err = 1'b0;
    m_cnt = 0;
  endtask

  task automatic check_outs();
    logic [NUM_OUT-1:0]        ev;
    logic [NUM_OUT*DATA_W-1:0] ed;
    for (int k = 0; k < NUM_OUT; k++) begin
      ev[k]            = m_full[k];
      ed[k*2 +: 2]     = m_data[k];
      seen[k]         += int'(bus.out_valid[k]);
    end
    chk("out_valid", 64'(bus.out_valid), 64'(ev));
    chk("out_data", 64'(bus.out_data), 64'(ed));
    chk("err_sel", 64'(bus.err_sel), 64'(m_err));
`ifdef DEMUX_STATS_EN
    chk("drop_cnt", 64'(drop_cnt), 64'(m_cnt));
`endif
  endtask

  // One clock: check in_ready mid-cycle, advance the model, check outputs after the edge.
  task automatic tick();
    bit exp_rdy;
    bit acc;
    int s;
    @(negedge clk);
    s       = int'(bus.in_sel);
    exp_rdy = (s >= NUM_OUT) ? 1'b1 : (!m_full[s] || bus.out_ready[s]);
    chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    acc = bus.in_valid && exp_rdy;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (acc && s == k) begin
        m_full[k] = 1'b1;
        m_data[k] = bus.in_data;
      end else if (m_full[k] && bus.out_ready[k]) begin
        m_full[k] = 1'b0;
      end
    end
    m_err = acc && (s >= NUM_OUT);
`ifdef DEMUX_STATS_EN
    if (drop_clr) m_cnt = 0;
    else if (m_err && m_cnt < 255) m_cnt++;
`endif
    @(posedge clk);
    #1;
    check_outs();
  endtask

  task automatic send(input int sel, input logic [1:0] data);
    bus.in_valid = 1'b1;
    bus.in_sel   = SEL_W'(sel);
    bus.in_data  = data;
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sel    = '0;
    bus.in_data   = '0;
    bus.out_ready = '0;
`ifdef DEMUX_STATS_EN
    drop_clr = 1'b0;
`endif
    model_clear();
    @(posedge clk);
    #1;
    check_outs();
    rst_n = 1'b1;

    // 1: asynchronous reset with slots 3 and 17 full
    send(3, 2'b01);
    send(17, 2'b10);
    chk("pre_rst_v17", 64'(bus.out_valid[17]), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_data", 64'(bus.out_data), 64'd0);
    chk("rst_err", 64'(bus.err_sel), 64'd0);
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 2: route to 13, stall, then drain
    send(13, 2'b10);
    chk("route_v13", 64'(bus.out_valid[13]), 64'd1);
    chk("route_d13", 64'(bus.out_data[27:26]), 64'd2);
    bus.in_valid = 1'b1;
    bus.in_sel   = 5'd13;
    bus.in_data  = 2'b01;
    #1;
    chk("stall_rdy", 64'(bus.in_ready), 64'd0);
    tick();
    bus.in_valid      = 1'b0;
    bus.out_ready[13] = 1'b1;
    tick();
    chk("drain_v13", 64'(bus.out_valid[13]), 64'd0);
    bus.out_ready = '0;

    // 3: simultaneous accept and drain on slot 5
    send(5, 2'b01);
    bus.out_ready[5] = 1'b1;
    send(5, 2'b11);
    chk("simul_v5", 64'(bus.out_valid[5]), 64'd1);
    chk("simul_d5", 64'(bus.out_data[11:10]), 64'd3);
    bus.out_ready = '0;

    // 4: stalled 12 does not block 13
    send(12, 2'b01);
    send(13, 2'b11);
    chk("indep_v12", 64'(bus.out_valid[12]), 64'd1);
    chk("indep_v13", 64'(bus.out_valid[13]), 64'd1);

    // 5: illegal select is accepted, dropped, flagged for one cycle
    send(31, 2'b10);
    chk("illegal_err", 64'(bus.err_sel), 64'd1);
    tick();
    chk("illegal_err_end", 64'(bus.err_sel), 64'd0);
`ifdef DEMUX_STATS_EN
    for (int i = 0; i < 299; i++) send(31, 2'(i));
    chk("cnt_sat", 64'(drop_cnt), 64'd255);
    drop_clr = 1'b1;
    tick();
    drop_clr = 1'b0;
    chk("cnt_clr", 64'(drop_cnt), 64'd0);
`endif

    // 6: sweep every channel with all consumers ready
    bus.out_ready = '1;
    tick();
    for (int k = 0; k < NUM_OUT; k++) seen[k] = 0;
    for (int k = 0; k < NUM_OUT; k++) send(k, 2'(k));
    tick();
    for (int k = 0; k < NUM_OUT; k++) chk($sformatf("sweep_seen%0d", k), 64'(seen[k]), 64'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_sel    = 5'($urandom_range(0, 31));
      bus.in_data   = 2'($urandom);
      bus.out_ready = NUM_OUT'($urandom) & NUM_OUT'($urandom);
`ifdef DEMUX_STATS_EN
      drop_clr = ($urandom_range(0, 19) == 0);
`endif
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
